// File: rtl/u400_bus_master.sv
// u400_bus_master: 68040 local-bus initiator. Arbitrates with BR/BG/BB, issues
// one single or 4-beat line transfer per request, counts TA beats, aborts on TEA
// and reports BEAT / DONE / ERR strobes to the internal requester.
// Latency: REQ to BRn low 1 clock; grant sample to TSn low 1 clock; DONE 2 clocks
// after the terminating TA/TEA sample. Backpressure: REQ is held until DONE;
// while the bus is not granted the block simply waits in arbitration.
//
// Optional feature macro: BUS_MASTER_TIMEOUT_EN (adds TIMEOUT_CYCLES parameter
// and a per-beat watchdog that terminates the transfer with ERR).
//
// Ports:
//   CLK40, RESETn          clock, synchronous active-low reset
//   REQ, REQ_RnW, REQ_SIZ, REQ_A   request from the internal requester
//   BGn, BBn_IN, TAn, TEAn  bus arbitration / termination inputs
//   BRn, BBn, BB_OE         bus request and bus-busy drive
//   TSn, TIPn, A, SIZ, RnW, BUS_OE  transfer control pads
//   BEAT, DONE, ERR         status strobes toward the requester

module u400_bus_master
`ifdef BUS_MASTER_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 256)
`endif
  (
  input  logic        CLK40,
  input  logic        RESETn,
  input  logic        REQ,
  input  logic        REQ_RnW,
  input  logic [1:0]  REQ_SIZ,
  input  logic [31:0] REQ_A,
  input  logic        BGn,
  input  logic        BBn_IN,
  input  logic        TAn,
  input  logic        TEAn,
  output logic        BRn,
  output logic        BBn,
  output logic        BB_OE,
  output logic        TSn,
  output logic        TIPn,
  output logic [31:0] A,
  output logic [1:0]  SIZ,
  output logic        RnW,
  output logic        BUS_OE,
  output logic        BEAT,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_START   = 3'd2,
    S_DATA    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t      state_q,    state_d;
  logic        brn_q,      brn_d;
  logic        bbn_q,      bbn_d;
  logic        bb_oe_q,    bb_oe_d;
  logic        tsn_q,      tsn_d;
  logic        tipn_q,     tipn_d;
  logic [31:0] a_q,        a_d;
  logic [1:0]  siz_q,      siz_d;
  logic        rnw_q,      rnw_d;
  logic        bus_oe_q,   bus_oe_d;
  logic        beat_q,     beat_d;
  logic        done_q,     done_d;
  logic        err_q,      err_d;
  logic [1:0]  beat_cnt_q, beat_cnt_d;
  logic        err_flag_q, err_flag_d;
  logic        last_beat;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  // The count reaches TIMEOUT_CYCLES-1 after that many idle DATA clocks; the
  // next idle sample is the one that gives up.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  // Line transfers end on the 4th TA; all other sizes end on the first.
  assign last_beat = (siz_q != 2'b11) || (beat_cnt_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    brn_d      = brn_q;
    bbn_d      = bbn_q;
    bb_oe_d    = bb_oe_q;
    tsn_d      = tsn_q;
    tipn_d     = tipn_q;
    a_d        = a_q;
    siz_d      = siz_q;
    rnw_d      = rnw_q;
    bus_oe_d   = bus_oe_q;
    beat_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    beat_cnt_d = beat_cnt_q;
    err_flag_d = err_flag_q;
`ifdef BUS_MASTER_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        // BB was driven high for the RELEASE clock; let the pull-up take over.
        bb_oe_d = 1'b0;
        if (REQ) begin
          a_d     = REQ_A;
          siz_d   = REQ_SIZ;
          rnw_d   = REQ_RnW;
          brn_d   = 1'b0;
          state_d = S_ARB;
        end
      end

      S_ARB: begin
        // Grant alone is not enough: the previous owner must have released BB.
        if (!BGn && BBn_IN) begin
          bus_oe_d = 1'b1;
          bb_oe_d  = 1'b1;
          bbn_d    = 1'b0;
          tsn_d    = 1'b0;
          tipn_d   = 1'b0;
          brn_d    = 1'b1;
          state_d  = S_START;
        end
      end

      S_START: begin
        tsn_d      = 1'b1;
        beat_cnt_d = 2'd0;
        err_flag_d = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
        tmo_d      = '0;
`endif
        state_d    = S_DATA;
      end

      S_DATA: begin
        if (!TEAn) begin
          // TEA wins over a simultaneous TA and ends the transfer immediately.
          err_flag_d = 1'b1;
          state_d    = S_RELEASE;
        end else if (!TAn) begin
          beat_d     = 1'b1;
          beat_cnt_d = beat_cnt_q + 2'd1;
`ifdef BUS_MASTER_TIMEOUT_EN
          tmo_d      = '0;
`endif
          if (last_beat) begin
            state_d = S_RELEASE;
          end
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        else if (tmo_hit) begin
          err_flag_d = 1'b1;
          state_d    = S_RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end

      S_RELEASE: begin
        done_d   = 1'b1;
        err_d    = err_flag_q;
        tipn_d   = 1'b1;
        bus_oe_d = 1'b0;
        bbn_d    = 1'b1;
        bb_oe_d  = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      brn_q      <= 1'b1;
      bbn_q      <= 1'b1;
      bb_oe_q    <= 1'b0;
      tsn_q      <= 1'b1;
      tipn_q     <= 1'b1;
      a_q        <= 32'h0;
      siz_q      <= 2'b00;
      rnw_q      <= 1'b1;
      bus_oe_q   <= 1'b0;
      beat_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      beat_cnt_q <= 2'd0;
      err_flag_q <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      brn_q      <= brn_d;
      bbn_q      <= bbn_d;
      bb_oe_q    <= bb_oe_d;
      tsn_q      <= tsn_d;
      tipn_q     <= tipn_d;
      a_q        <= a_d;
      siz_q      <= siz_d;
      rnw_q      <= rnw_d;
      bus_oe_q   <= bus_oe_d;
      beat_q     <= beat_d;
      done_q     <= done_d;
      err_q      <= err_d;
      beat_cnt_q <= beat_cnt_d;
      err_flag_q <= err_flag_d;
`ifdef BUS_MASTER_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign BRn    = brn_q;
  assign BBn    = bbn_q;
  assign BB_OE  = bb_oe_q;
  assign TSn    = tsn_q;
  assign TIPn   = tipn_q;
  assign A      = a_q;
  assign SIZ    = siz_q;
  assign RnW    = rnw_q;
  assign BUS_OE = bus_oe_q;
  assign BEAT   = beat_q;
  assign DONE   = done_q;
  assign ERR    = err_q;

endmodule

// File: doc/u400_bus_master.md
# u400_bus_master

Local-bus initiator for the AmigaPCI 68040 local bus. It arbitrates for the bus with the 68040 BR/BG/BB protocol and launches single transfers or 4-beat line transfers toward local responders such as the SDRAM controller. It counts TA acknowledges, or aborts on TEA, and reports per-beat and completion strobes to an internal requester such as the PCI bridge or a DMA engine. This block handles control only; the data path latches on BEAT.

## Interface
- TIMEOUT_CYCLES, 256: clocks allowed between TSn and each TA or TEA before forced termination. Used only with BUS_MASTER_TIMEOUT_EN.
- CLK40  in  1  40 MHz local bus clock. All logic updates on the rising edge.
- RESETn  in  1  synchronous, active-low reset.
- REQ  in  1  transfer request. Held high until DONE.
- REQ_RnW  in  1  1 = read, 0 = write.
- REQ_SIZ  in  2  68040 size encoding: 00 long, 01 byte, 10 word, 11 line (4 beats).
- REQ_A  in  32  transfer address.
- BGn  in  1  bus grant from the arbiter.
- BBn_IN  in  1  sensed bus-busy line.
- TAn  in  1  transfer acknowledge (pulled up when undriven).
- TEAn  in  1  transfer error acknowledge.
- BRn  out  1  bus request.
- BBn  out  1  bus-busy drive value. Valid when BB_OE=1.
- BB_OE  out  1  BBn output enable.
- TSn  out  1  transfer start, one clock wide.
- TIPn  out  1  transfer in progress.
- A  out  32  latched address. Valid when BUS_OE=1.
- SIZ  out  2  latched size. Valid when BUS_OE=1.
- RnW  out  1  latched direction. Valid when BUS_OE=1.
- BUS_OE  out  1  enable for A, SIZ, RnW and TIPn pads.
- BEAT  out  1  one-clock pulse for each accepted TA.
- DONE  out  1  one-clock pulse when the transfer ends.
- ERR  out  1  one-clock pulse coincident with DONE on TEA or timeout.

## Operation
- States: IDLE, ARB, START, DATA, RELEASE.
- IDLE:
  - On REQ=1, latch REQ_A, REQ_SIZ and REQ_RnW.
  - Set BRn=0 and go to ARB.
- ARB:
  - Wait until BGn=0 and BBn_IN=1 are sampled in the same clock.
  - Then: BUS_OE=1, BB_OE=1, BBn=0, TSn=0, TIPn=0, BRn=1. Go to START.
- START:
  - TSn=1. Clear the beat counter and the timeout counter. Go to DATA.
- DATA, TAn=0 and TEAn=1:
  - Pulse BEAT and increment the 2-bit beat counter.
  - The last beat is beat 1 for non-line transfers and beat 4 for line transfers.
  - On the last beat, go to RELEASE.
- DATA, TEAn=0:
  - Abort regardless of TAn or the beat count. TEA has priority over TA.
  - No BEAT pulse. Set an internal error flag and go to RELEASE.
- RELEASE:
  - Pulse DONE, plus ERR if the error flag is set.
  - TIPn=1, BUS_OE=0, BBn=1 with BB_OE=1 for this single clock.
  - Next clock: BB_OE=0, go to IDLE.
- Back-to-back requests: REQ still high in IDLE after DONE is a new request. The minimum gap between two TSn assertions is 5 clocks.
- Bus grant: BGn deasserted while in ARB leaves the block waiting in ARB. After TSn has been issued, BGn is ignored; the current transfer always completes.
- Reset, including mid-burst: every output returns to its reset value on the next edge and the state becomes IDLE. No DONE is issued for the aborted transfer.

## Timing
- Reset values: BRn=1, BBn=1, BB_OE=0, TSn=1, TIPn=1, BUS_OE=0, BEAT=0, DONE=0, ERR=0, A=0, SIZ=0, RnW=1.
- Latency: REQ edge to BRn low is 1 clock. Grant sample to TSn low is 1 clock.
- TAn and TEAn are sampled on the rising edge. BEAT asserts on the clock after the sampled TA.
- A responder asserting TA on the 2nd clock after TSn gives DONE 4 clocks after TSn for a single transfer.
- TA may be held low across consecutive clocks. Each sampled low counts as one beat, so a 4-beat burst needs 4 sampled TAs.

## Configuration
- BUS_MASTER_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter increments in DATA and reloads to 0 on every accepted TA.
  - Reaching TIMEOUT_CYCLES with no TA or TEA has the same effect as TEA: ERR and DONE in RELEASE.
- BUS_MASTER_TIMEOUT_EN not defined:
  - No counter. DATA waits for TA or TEA indefinitely.

## Test plan
- Long read at 0x0800_0010, BGn low, TA two clocks after TSn -> one TSn pulse, BEAT=1 once, DONE 4 clocks after TSn, ERR=0, RnW=1 while BUS_OE=1.
- Line write (SIZ=11), TA on 4 consecutive clocks -> 4 BEAT pulses, DONE on the clock after the 4th beat, BBn driven high for one clock, then BB_OE=0.
- BGn held high for 10 clocks after REQ -> BRn low throughout, TSn high, BUS_OE=0. Grant arrives -> TSn low on the next clock.
- Line read, TEAn low at beat 2 -> 1 BEAT only, DONE and ERR pulse together, TIPn=1.
- Macro defined, TIMEOUT_CYCLES=16, no TA -> ERR and DONE 17-18 clocks after TSn. Macro undefined -> DONE never asserts.
- RESETn low after beat 2 of a line read -> all outputs at reset values next edge, no DONE. New REQ after reset completes normally.
